// File: rtl/seq_alu_md.sv
// seq_alu_md: RV32 execute-stage ALU, single-cycle base ops plus iterative RV32M mul/div.
// Optional macro FAST_MUL_EN: all MUL* ops use a single-cycle multiplier (latency 1).
module seq_alu_md #(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [4:0]   sel,
    output logic         out_valid,
    output logic [N-1:0] result,
    output logic         zero_flag,
    output logic         sign_flag,
    output logic         carry_flag,
    output logic         overflow_flag
);
    localparam int SH_W = $clog2(N);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLL  = 5'b00111;
    localparam logic [4:0] OP_SRL  = 5'b01000;
    localparam logic [4:0] OP_SRA  = 5'b01001;
    localparam logic [4:0] OP_SLT  = 5'b01010;
    localparam logic [4:0] OP_SLTU = 5'b01011;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       result_q, result_d;
    logic               zero_q, zero_d, sign_q, sign_d, carry_q, carry_d, ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [2*N-1:0]     mcand_q, mcand_d, prod_q, prod_d;
    logic [N-1:0]       mplier_q, mplier_d, rem_q, rem_d, quo_q, quo_d, divisor_q, divisor_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d, rneg_q, rneg_d;

    logic [N:0]         add_sum;
    logic [N-1:0]       b_eff, base_res;
    logic               is_sub, add_ovf, base_c, base_v;
    logic [SH_W-1:0]    shamt;
    logic               sa, sb, a_neg, b_neg;
    logic [N-1:0]       a_mag, b_mag;
    logic [2*N-1:0]     mul_acc, mul_fin;
    logic [N:0]         div_rs, div_trial;
    logic               div_ge;
    logic [N-1:0]       rem_nxt, quo_nxt;
    logic               done, done_c, done_v;
    logic [N-1:0]       done_res;
`ifdef FAST_MUL_EN
    logic [2*N-1:0]     fast_p;
`endif

    function automatic logic [N-1:0] neg_if(input logic [N-1:0] v, input logic en);
        return en ? (~v + {{(N-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*N-1:0] neg_if2(input logic [2*N-1:0] v, input logic en);
        return en ? (~v + {{(2*N-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Single-cycle base ALU; SUB reuses the adder with an inverted operand and carry-in.
    always_comb begin
        is_sub  = (sel == OP_SUB);
        b_eff   = is_sub ? ~B : B;
        add_sum = {1'b0, A} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
        add_ovf = (A[N-1] == b_eff[N-1]) & (add_sum[N-1] != A[N-1]);
        shamt   = B[SH_W-1:0];
        base_c  = 1'b0;
        base_v  = 1'b0;
        case (sel)
            OP_AND:  base_res = A & B;
            OP_OR:   base_res = A | B;
            OP_XOR:  base_res = A ^ B;
            OP_ADD, OP_SUB: begin
                base_res = add_sum[N-1:0];
                base_c   = add_sum[N];
                base_v   = add_ovf;
            end
            OP_SLL:  base_res = A << shamt;
            OP_SRL:  base_res = A >> shamt;
            OP_SRA:  base_res = $signed(A) >>> shamt;
            OP_SLT:  base_res = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: base_res = {{(N-1){1'b0}}, (A < B)};
            default: base_res = '0;
        endcase
    end

    // Operand signedness: div ops signed when sel[0]=0; MULHSU signs A only, MULHU neither.
    always_comb begin
        sa    = sel[2] ? ~sel[0] : ~(sel[1] & sel[0]);
        sb    = sel[2] ? ~sel[0] : ~sel[1];
        a_neg = sa & A[N-1];
        b_neg = sb & B[N-1];
        a_mag = neg_if(A, a_neg);
        b_mag = neg_if(B, b_neg);
    end

    // One shift-add step and one restoring-division step per MUL/DIV cycle.
    always_comb begin
        mul_acc   = prod_q + (mplier_q[0] ? mcand_q : {(2*N){1'b0}});
        mul_fin   = neg_if2(mul_acc, neg_q);
        div_rs    = {rem_q, quo_q[N-1]};
        div_trial = div_rs - {1'b0, divisor_q};
        div_ge    = (div_rs >= {1'b0, divisor_q});
        rem_nxt   = div_ge ? div_trial[N-1:0] : div_rs[N-1:0];
        quo_nxt   = {quo_q[N-2:0], div_ge};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        zero_d      = zero_q;
        sign_d      = sign_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        mplier_d    = mplier_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        op_d        = op_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        done        = 1'b0;
        done_res    = '0;
        done_c      = 1'b0;
        done_v      = 1'b0;
`ifdef FAST_MUL_EN
        fast_p      = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (sel[4:3] == 2'b10) begin
                        if (!sel[2]) begin
`ifdef FAST_MUL_EN
                            fast_p   = neg_if2({{N{1'b0}}, a_mag} * {{N{1'b0}}, b_mag},
                                               a_neg ^ b_neg);
                            done     = 1'b1;
                            done_res = (sel[1:0] == 2'b00) ? fast_p[N-1:0] : fast_p[2*N-1:N];
`else
                            mcand_d  = {{N{1'b0}}, a_mag};
                            mplier_d = b_mag;
                            prod_d   = '0;
                            neg_d    = a_neg ^ b_neg;
                            op_d     = sel[1:0];
                            cnt_d    = '0;
                            state_d  = S_MUL;
`endif
                        end else if (B == '0) begin
                            done     = 1'b1;
                            done_res = sel[1] ? A : '1;
                        end else if (sa && (A == {1'b1, {(N-1){1'b0}}}) && (B == '1)) begin
                            done     = 1'b1;
                            done_res = sel[1] ? '0 : A;
                        end else begin
                            quo_d     = a_mag;
                            rem_d     = '0;
                            divisor_d = b_mag;
                            neg_d     = a_neg ^ b_neg;
                            rneg_d    = a_neg;
                            op_d      = sel[1:0];
                            cnt_d     = '0;
                            state_d   = S_DIV;
                        end
                    end else begin
                        done     = 1'b1;
                        done_res = base_res;
                        done_c   = base_c;
                        done_v   = base_v;
                    end
                end
            end
            S_MUL: begin
                prod_d   = mul_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    done     = 1'b1;
                    done_res = (op_q == 2'b00) ? mul_fin[N-1:0] : mul_fin[2*N-1:N];
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            S_DIV: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    done     = 1'b1;
                    done_res = op_q[1] ? neg_if(rem_nxt, rneg_q) : neg_if(quo_nxt, neg_q);
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (done) begin
            result_d    = done_res;
            zero_d      = (done_res == '0);
            sign_d      = done_res[N-1];
            carry_d     = done_c;
            ovf_d       = done_v;
            out_valid_d = 1'b1;
        end
        // Flush drops any completion, including one from a same-cycle accept.
        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            result_d    = result_q;
            zero_d      = zero_q;
            sign_d      = sign_q;
            carry_d     = carry_q;
            ovf_d       = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            sign_q      <= sign_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Iteration datapath carries no reset; it is always reloaded on accept.
    always_ff @(posedge clk) begin
        mcand_q   <= mcand_d;
        prod_q    <= prod_d;
        mplier_q  <= mplier_d;
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        divisor_q <= divisor_d;
        op_q      <= op_d;
        neg_q     <= neg_d;
        rneg_q    <= rneg_d;
    end

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign zero_flag     = zero_q;
    assign sign_flag     = sign_q;
    assign carry_flag    = carry_q;
    assign overflow_flag = ovf_q;

endmodule
